// File: rtl/tft_ili9341_region_scheduler.sv
// Round-robin scheduler sharing the ILI9341 byte link between two rectangle requesters.
// Emits CASET, PASET, RAMWR and every pixel of the winning region as {dc, byte} words.
module tft_ili9341_region_scheduler #(
    parameter int X_MAX   = 319,
    parameter int Y_MAX   = 239,
    parameter int COORD_W = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               req_valid,
    output logic [1:0]               req_ready,
    input  logic [2*4*COORD_W-1:0]   req_rect,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    input  logic [15:0]              pix_data,
    output logic [1:0]               grant,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [8:0]               out_data,
    output logic                     busy,
    output logic [1:0]               done,
    output logic [1:0]               err
);

    localparam int RECT_W = 4 * COORD_W;
    localparam logic [COORD_W-1:0] XMAX_C = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] YMAX_C = COORD_W'(Y_MAX);
    localparam logic [COORD_W-1:0] ONE_C  = COORD_W'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACCEPT = 3'd1;
    localparam logic [2:0] S_CMD    = 3'd2;
    localparam logic [2:0] S_PIX_HI = 3'd3;
    localparam logic [2:0] S_PIX_LO = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]         state_q, state_d;
    logic               rr_last_q, rr_last_d;
    logic               owner_q, owner_d;
    logic [1:0]         req_ready_q, req_ready_d;
    logic [1:0]         grant_q, grant_d;
    logic [1:0]         done_q, done_d;
    logic [1:0]         err_q, err_d;
    logic [COORD_W-1:0] x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
    logic [COORD_W-1:0] col_q, col_d, row_q, row_d;
    logic [3:0]         idx_q, idx_d;
    logic [7:0]         pix_lo_q, pix_lo_d;
    logic               out_valid_q, out_valid_d;
    logic [8:0]         out_data_q, out_data_d;

    logic [RECT_W-1:0]  sel_rect;
    logic [COORD_W-1:0] rx0, rx1, ry0, ry1;
    logic               rect_bad;
    logic               pref, win;
    logic [15:0]        x0e, x1e, y0e, y1e;
    logic [8:0]         cmd_word;

    // Rectangle of the requester that was offered req_ready, checked in the transfer cycle.
    always_comb begin
        sel_rect = owner_q ? req_rect[2*RECT_W-1 -: RECT_W] : req_rect[RECT_W-1:0];
        rx0      = sel_rect[4*COORD_W-1 -: COORD_W];
        rx1      = sel_rect[3*COORD_W-1 -: COORD_W];
        ry0      = sel_rect[2*COORD_W-1 -: COORD_W];
        ry1      = sel_rect[COORD_W-1:0];
        rect_bad = (rx0 > rx1) || (ry0 > ry1) || (rx1 > XMAX_C) || (ry1 > YMAX_C);
        pref     = ~rr_last_q;
        win      = req_valid[pref] ? pref : rr_last_q;
    end

    always_comb begin
        x0e = 16'(x0_q);
        x1e = 16'(x1_q);
        y0e = 16'(y0_q);
        y1e = 16'(y1_q);
        case (idx_q)
            4'd0:    cmd_word = {1'b0, 8'h2A};
            4'd1:    cmd_word = {1'b1, x0e[15:8]};
            4'd2:    cmd_word = {1'b1, x0e[7:0]};
            4'd3:    cmd_word = {1'b1, x1e[15:8]};
            4'd4:    cmd_word = {1'b1, x1e[7:0]};
            4'd5:    cmd_word = {1'b0, 8'h2B};
            4'd6:    cmd_word = {1'b1, y0e[15:8]};
            4'd7:    cmd_word = {1'b1, y0e[7:0]};
            4'd8:    cmd_word = {1'b1, y1e[15:8]};
            4'd9:    cmd_word = {1'b1, y1e[7:0]};
            4'd10:   cmd_word = {1'b0, 8'h2C};
            default: cmd_word = 9'h000;
        endcase
    end

    // Each state either loads its word into the empty output slot or waits for it to drain.
    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        owner_d     = owner_q;
        req_ready_d = 2'b00;
        grant_d     = grant_q;
        done_d      = 2'b00;
        err_d       = 2'b00;
        x0_d        = x0_q;
        x1_d        = x1_q;
        y0_d        = y0_q;
        y1_d        = y1_q;
        col_d       = col_q;
        row_d       = row_q;
        idx_d       = idx_q;
        pix_lo_d    = pix_lo_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    owner_d     = win;
                    rr_last_d   = win;
                    grant_d     = {win, ~win};
                    req_ready_d = {win, ~win};
                    state_d     = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                if (!req_valid[owner_q]) begin
                    grant_d = 2'b00;
                    state_d = S_IDLE;
                end else if (rect_bad) begin
                    err_d   = grant_q;
                    grant_d = 2'b00;
                    state_d = S_IDLE;
                end else begin
                    x0_d    = rx0;
                    x1_d    = rx1;
                    y0_d    = ry0;
                    y1_d    = ry1;
                    col_d   = rx0;
                    row_d   = ry0;
                    idx_d   = 4'd0;
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = cmd_word;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (idx_q == 4'd10) state_d = S_PIX_HI;
                    else                idx_d   = idx_q + 4'd1;
                end
            end
            S_PIX_HI: begin
                if (!out_valid_q) begin
                    if (pix_valid) begin
                        pix_lo_d    = pix_data[7:0];
                        out_valid_d = 1'b1;
                        out_data_d  = {1'b1, pix_data[15:8]};
                    end
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_PIX_LO;
                end
            end
            S_PIX_LO: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = {1'b1, pix_lo_q};
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (col_q == x1_q) begin
                        if (row_q == y1_q) begin
                            state_d = S_DONE;
                        end else begin
                            col_d   = x0_q;
                            row_d   = row_q + ONE_C;
                            state_d = S_PIX_HI;
                        end
                    end else begin
                        col_d   = col_q + ONE_C;
                        state_d = S_PIX_HI;
                    end
                end
            end
            S_DONE: begin
                done_d  = grant_q;
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_last_q   <= 1'b1;
            owner_q     <= 1'b0;
            req_ready_q <= 2'b00;
            grant_q     <= 2'b00;
            done_q      <= 2'b00;
            err_q       <= 2'b00;
            x0_q        <= '0;
            x1_q        <= '0;
            y0_q        <= '0;
            y1_q        <= '0;
            col_q       <= '0;
            row_q       <= '0;
            idx_q       <= 4'd0;
            pix_lo_q    <= 8'h00;
            out_valid_q <= 1'b0;
            out_data_q  <= 9'h000;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            owner_q     <= owner_d;
            req_ready_q <= req_ready_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            err_q       <= err_d;
            x0_q        <= x0_d;
            x1_q        <= x1_d;
            y0_q        <= y0_d;
            y1_q        <= y1_d;
            col_q       <= col_d;
            row_q       <= row_d;
            idx_q       <= idx_d;
            pix_lo_q    <= pix_lo_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Pixels are only taken into an empty output slot, so a stalled link never drops one.
    assign pix_ready = (state_q == S_PIX_HI) && !out_valid_q;
    assign busy      = (state_q != S_IDLE);
    assign req_ready = req_ready_q;
    assign grant     = grant_q;
    assign done      = done_q;
    assign err       = err_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_tft_ili9341_region_scheduler.sv
// Directed bench for the region scheduler: drives inputs on the falling edge and
// compares the accepted word stream against a small reference model of the byte sequence.
module tb_tft_ili9341_region_scheduler;

    localparam int CW = 9;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    req_valid = 2'b00;
    logic [1:0]    req_ready;
    logic [8*CW-1:0] req_rect = '0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [15:0]   pix_data = 16'h0000;
    logic [1:0]    grant;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [8:0]    out_data;
    logic          busy;
    logic [1:0]    done;
    logic [1:0]    err;

    tft_ili9341_region_scheduler #(.X_MAX(319), .Y_MAX(239), .COORD_W(CW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rect(req_rect),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .grant(grant), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checksTotal = 0;
    int checksPassed = 0;

    logic [8:0]  wordQ[$];
    logic [8:0]  expQ[$];
    logic [1:0]  grantSeq[$];
    int          fetchCnt, doneCnt, errCnt, validSeen, stabViol, pixViol;
    logic [1:0]  doneVal, errVal;
    logic [15:0] pixBase, pixStep;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checksTotal++;
        if (observed === expected) checksPassed++;
        else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    function automatic logic [4*CW-1:0] packRect(input int x0, input int x1, input int y0, input int y1);
        return {CW'(x0), CW'(x1), CW'(y0), CW'(y1)};
    endfunction

    task automatic pushCoordPair(input int a, input int b);
        logic [15:0] va, vb;
        va = 16'(a);
        vb = 16'(b);
        expQ.push_back({1'b1, va[15:8]});
        expQ.push_back({1'b1, va[7:0]});
        expQ.push_back({1'b1, vb[15:8]});
        expQ.push_back({1'b1, vb[7:0]});
    endtask

    // Reference stream: command preamble then one hi/lo pair per pixel in fetch order.
    task automatic buildExpected(input int x0, input int x1, input int y0, input int y1);
        logic [15:0] p;
        int n;
        expQ.delete();
        expQ.push_back(9'h02A);
        pushCoordPair(x0, x1);
        expQ.push_back(9'h02B);
        pushCoordPair(y0, y1);
        expQ.push_back(9'h02C);
        n = (x1 - x0 + 1) * (y1 - y0 + 1);
        for (int k = 0; k < n; k++) begin
            p = pixBase + 16'(k) * pixStep;
            expQ.push_back({1'b1, p[15:8]});
            expQ.push_back({1'b1, p[7:0]});
        end
    endtask

    task automatic compareStream(input string name);
        checkOutput({name, "_len"}, wordQ.size(), expQ.size());
        for (int i = 0; i < expQ.size(); i++)
            if (i < wordQ.size())
                checkOutput($sformatf("%s_w%0d", name, i), {23'd0, wordQ[i]}, {23'd0, expQ[i]});
    endtask

    // One request from reqIdx; runs until done/err plus a short tail, or aborts by asserting reset.
    task automatic applyStimulus(input int reqIdx, input logic [4*CW-1:0] rect, input bit stall,
                                 input int abortAt, input int maxCycles);
        bit accepted = 0;
        bit finished = 0;
        bit prevStall = 0;
        logic [8:0] prevData = 9'h000;
        int tail = 0;
        wordQ.delete();
        fetchCnt = 0; doneCnt = 0; errCnt = 0; validSeen = 0; stabViol = 0; pixViol = 0;
        doneVal = 2'b00; errVal = 2'b00;
        @(negedge clk);
        req_rect[reqIdx*4*CW +: 4*CW] = rect;
        req_valid[reqIdx] = 1'b1;
        for (int c = 0; c < maxCycles && !finished; c++) begin
            @(negedge clk);
            if (abortAt != 0 && wordQ.size() == abortAt) begin
                reset = 1'b1;
                req_valid = 2'b00;
                finished = 1;
            end else begin
                if (accepted) req_valid = 2'b00;
                out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                pix_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                pix_data  = pixBase + 16'(fetchCnt) * pixStep;
                if (req_ready[reqIdx]) accepted = 1;
                if (prevStall && (!out_valid || out_data !== prevData)) stabViol++;
                if (pix_ready && out_valid) pixViol++;
                if (out_valid) validSeen++;
                if (out_valid && out_ready) wordQ.push_back(out_data);
                if (pix_valid && pix_ready) fetchCnt++;
                prevStall = out_valid && !out_ready;
                prevData  = out_data;
                if (done != 2'b00) begin doneCnt++; doneVal |= done; end
                if (err != 2'b00) begin errCnt++; errVal |= err; end
                if (doneCnt > 0 || errCnt > 0) begin
                    tail++;
                    if (tail > 3) finished = 1;
                end
            end
        end
        checkOutput("jobFinished", {31'd0, finished}, 32'd1);
        pix_valid = 1'b0;
    endtask

    initial begin
        pixBase = 16'hF800;
        pixStep = 16'h0000;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_req_ready", {30'd0, req_ready}, 32'd0);
        checkOutput("rst_pix_ready", {31'd0, pix_ready}, 32'd0);
        checkOutput("rst_grant",     {30'd0, grant}, 32'd0);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_out_data",  {23'd0, out_data}, 32'd0);
        checkOutput("rst_busy",      {31'd0, busy}, 32'd0);
        checkOutput("rst_done",      {30'd0, done}, 32'd0);
        checkOutput("rst_err",       {30'd0, err}, 32'd0);
        reset = 1'b0;

        // 1x1 region from requester 0
        applyStimulus(0, packRect(0, 0, 0, 0), 0, 0, 200);
        buildExpected(0, 0, 0, 0);
        compareStream("t1");
        checkOutput("t1_doneCnt", doneCnt, 1);
        checkOutput("t1_doneVal", {30'd0, doneVal}, 32'd1);

        // Invalid rectangles are rejected without any output
        applyStimulus(0, packRect(5, 3, 0, 0), 0, 0, 60);
        checkOutput("t3a_errCnt", errCnt, 1);
        checkOutput("t3a_errVal", {30'd0, errVal}, 32'd1);
        checkOutput("t3a_valid", validSeen, 0);
        checkOutput("t3a_done", doneCnt, 0);
        applyStimulus(1, packRect(0, 320, 0, 0), 0, 0, 60);
        checkOutput("t3b_errCnt", errCnt, 1);
        checkOutput("t3b_errVal", {30'd0, errVal}, 32'd2);
        checkOutput("t3b_valid", validSeen, 0);
        pixBase = 16'h1234;
        pixStep = 16'h0101;
        applyStimulus(0, packRect(0, 0, 239, 239), 0, 0, 200);
        buildExpected(0, 0, 239, 239);
        compareStream("t3c");
        checkOutput("t3c_err", errCnt, 0);

        // Coordinates above 255 need the high byte; 2x2 region fetches exactly 4 pixels
        applyStimulus(1, packRect(300, 318, 20, 20), 0, 0, 400);
        buildExpected(300, 318, 20, 20);
        compareStream("t4a");
        checkOutput("t4a_doneVal", {30'd0, doneVal}, 32'd2);
        applyStimulus(0, packRect(10, 11, 20, 21), 0, 0, 200);
        buildExpected(10, 11, 20, 21);
        compareStream("t4b");
        checkOutput("t4b_fetch", fetchCnt, 4);

        // Random stalls on a 4x3 region must not change the word stream
        pixBase = 16'hA50F;
        pixStep = 16'h1357;
        applyStimulus(1, packRect(2, 5, 7, 9), 1, 0, 3000);
        buildExpected(2, 5, 7, 9);
        compareStream("t5");
        checkOutput("t5_fetch", fetchCnt, 12);
        checkOutput("t5_stable", stabViol, 0);
        checkOutput("t5_pixGuard", pixViol, 0);
        checkOutput("t5_doneCnt", doneCnt, 1);

        // Reset while the first low byte is pending aborts at once
        applyStimulus(0, packRect(0, 1, 0, 1), 0, 12, 200);
        @(negedge clk);
        checkOutput("t6_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("t6_grant", {30'd0, grant}, 32'd0);
        checkOutput("t6_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        applyStimulus(0, packRect(3, 3, 4, 4), 0, 0, 200);
        buildExpected(3, 3, 4, 4);
        compareStream("t6");

        // Both requesters valid after reset: grants strictly alternate starting with 0
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        pix_valid = 1'b1;
        pix_data  = 16'h5555;
        req_rect  = {packRect(1, 1, 1, 1), packRect(0, 0, 0, 0)};
        req_valid = 2'b11;
        for (int c = 0; c < 600 && grantSeq.size() < 4; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00) grantSeq.push_back(grant);
        end
        @(negedge clk);
        req_valid = 2'b00;
        repeat (80) @(negedge clk);
        checkOutput("t2_len", grantSeq.size(), 4);
        for (int i = 0; i < grantSeq.size(); i++)
            checkOutput($sformatf("t2_grant%0d", i), {30'd0, grantSeq[i]}, (i % 2 == 0) ? 32'd1 : 32'd2);
        checkOutput("t2_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
